wb_stream_writer_ctrl: RTL and testbench



---
 rtl/wb_stream_writer_ctrl.sv | 159 +++++++++++++++
 tb/tb_wb_stream_writer_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst-read DMA controller: fetches a circular memory buffer in
// fixed-size bursts and pushes every returned word into the outgoing stream FIFO.
//
// state    | meaning
// S_IDLE   | no bus cycle; waits for a start pulse or for FIFO room for a whole burst
// S_ACTIVE | cyc/stb asserted, one word fetched per ack until the burst ends
module wb_stream_writer_ctrl #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 0,
    parameter int MAX_BURST_LEN = 0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,

    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,

    output logic [WB_DW-1:0]   fifo_d,
    output logic               fifo_wr,
    input  logic [FIFO_AW:0]   fifo_cnt,

    output logic               busy,
    output logic               err,
    input  logic               enable,
    output logic [WB_DW-1:0]   tx_cnt,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size
);

    localparam int BC_W = (MAX_BURST_LEN > 2) ? $clog2(MAX_BURST_LEN) : 1;
    localparam int FIFO_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FIFO_DEPTH_V = FIFO_DEPTH[FIFO_AW:0];

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1
    } state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [WB_DW-1:0] tx_cnt_q, tx_cnt_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [FIFO_AW:0] space;
    logic             fifo_ready;
    logic             burst_end;
    logic             last_adr;
    logic [WB_AW-1:0] buf_words;
    logic             unused_buf_lsb;

    // A burst is only launched when the FIFO can absorb all of it.
    assign space      = FIFO_DEPTH_V - fifo_cnt;
    assign fifo_ready = WB_AW'(space) >= burst_size;
    assign burst_end  = WB_AW'(burst_cnt_q) == (burst_size - WB_AW'(1));

    assign buf_words      = {2'b00, buf_size[WB_AW-1:2]};
    assign last_adr       = tx_cnt_q == WB_DW'(buf_words - WB_AW'(1));
    assign unused_buf_lsb = ^buf_size[1:0];

    assign wbm_adr_o = start_adr + (WB_AW'(tx_cnt_q) << 2);
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_bte_o = 2'b00;

    assign fifo_d = wbm_dat_i;
    assign busy   = busy_q;
    assign err    = err_q;
    assign tx_cnt = tx_cnt_q;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        err_d       = err_q;
        tx_cnt_d    = tx_cnt_q;
        burst_cnt_d = '0;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_cti_o   = CTI_CLASSIC;
        fifo_wr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !busy_q) begin
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    tx_cnt_d = '0;
                end
                if (busy_q && fifo_ready) begin
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                wbm_cyc_o   = 1'b1;
                wbm_stb_o   = 1'b1;
                wbm_cti_o   = burst_end ? CTI_EOB : CTI_INCR;
                burst_cnt_d = burst_cnt_q;

                // Error beats the ack: the word is discarded and the offset stays put.
                if (wbm_err_i) begin
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    burst_cnt_d = '0;
                end else if (wbm_ack_i) begin
                    fifo_wr  = 1'b1;
                    tx_cnt_d = last_adr ? '0 : tx_cnt_q + WB_DW'(1);
                    if (burst_end) begin
                        state_d     = S_IDLE;
                        burst_cnt_d = '0;
                        if (last_adr) begin
                            busy_d = 1'b0;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_cnt_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            tx_cnt_q    <= tx_cnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Self-checking bench for wb_stream_writer_ctrl: launch-condition vector table,
// hand-written corner sequences and randomized transfers against a beat scoreboard.
module tb_wb_stream_writer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;
    logic        werr = 1'b0;
    logic [31:0] fifo_d;
    logic        fifo_wr;
    logic [4:0]  fifo_cnt = '0;
    logic        busy;
    logic        err_o;
    logic        enable = 1'b0;
    logic [31:0] tx_cnt;
    logic [31:0] start_adr = '0;
    logic [31:0] buf_size = 32'd64;
    logic [31:0] burst_size = 32'd4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_stream_writer_ctrl #(
        .WB_AW(32), .WB_DW(32), .FIFO_AW(4), .MAX_BURST_LEN(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(werr),
        .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
        .busy(busy), .err(err_o), .enable(enable), .tx_cnt(tx_cnt),
        .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; ack = 1'b0; werr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: every word offset fetched once in order, bursts of burst_size beats,
    // an idle cycle after each burst, and launch only when the FIFO has room.
    task automatic run_xfer(input logic [31:0] sa, input logic [31:0] bsz,
                            input logic [31:0] bsl, input int waits, input bit rnd);
        int words, pushed, beat, waitc, n, bursts;
        bit prev_cyc, prev_busy, prev_ready, prev_end, cur_cyc;
        logic [31:0] word;
        words = int'(bsz) / 4;
        pushed = 0; beat = 0; waitc = 0; n = 0; bursts = 0;
        prev_cyc = 0; prev_busy = 0; prev_ready = 0; prev_end = 0;
        @(negedge clk);
        start_adr = sa; buf_size = bsz; burst_size = bsl; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("busy_set", 32'(busy), 1);
        check("tx_cnt_clr", tx_cnt, 0);
        check("cyc_before", 32'(cyc), 0);
        while (pushed < words && n < 4000) begin
            cur_cyc = cyc;
            if (prev_end) check("burst_gap", 32'(cyc), 0);
            else if (!prev_cyc && prev_busy) check("burst_start", 32'(cyc), 32'(prev_ready));
            if (cur_cyc) begin
                if (!prev_cyc) bursts++;
                check("adr", adr, sa + 32'(4 * pushed));
                check("stb", 32'(stb), 1);
                check("cti", 32'(cti), (beat == int'(bsl) - 1) ? 32'd7 : 32'd2);
            end else begin
                check("cti_idle", 32'(cti), 0);
                check("stb_idle", 32'(stb), 0);
            end
            if (rnd) begin
                ack = 1'($urandom_range(0, 1));
                fifo_cnt = 5'($urandom_range(0, 16));
            end else if (cur_cyc && waitc == waits) begin
                ack = 1'b1;
                waitc = 0;
            end else begin
                ack = 1'b0;
                waitc = cur_cyc ? waitc + 1 : 0;
            end
            word = $urandom;
            dat_i = word;
            prev_ready = (16 - int'(fifo_cnt)) >= int'(bsl);
            #1;
            check("fifo_wr", 32'(fifo_wr), 32'(cur_cyc && ack));
            if (cur_cyc && ack) begin
                check("fifo_d", fifo_d, word);
                pushed++;
                beat++;
                prev_end = (beat == int'(bsl));
                if (prev_end) beat = 0;
            end else begin
                prev_end = 0;
            end
            prev_cyc = cur_cyc;
            prev_busy = busy;
            @(negedge clk);
            n++;
        end
        ack = 1'b0;
        fifo_cnt = '0;
        check("words_pushed", 32'(pushed), 32'(words));
        check("bursts", 32'(bursts), 32'(words / int'(bsl)));
        check("busy_done", 32'(busy), 0);
        check("cyc_done", 32'(cyc), 0);
        check("tx_cnt_wrap", tx_cnt, 0);
        check("err_done", 32'(err_o), 0);
    endtask

    typedef struct {
        logic [4:0]  cnt;
        logic [31:0] bs;
        logic        exp_cyc;
        logic [2:0]  exp_cti;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{cnt: 5'd0,  bs: 32'd4,  exp_cyc: 1'b1, exp_cti: 3'b010};
        vecs[1] = '{cnt: 5'd12, bs: 32'd4,  exp_cyc: 1'b1, exp_cti: 3'b010};
        vecs[2] = '{cnt: 5'd13, bs: 32'd4,  exp_cyc: 1'b0, exp_cti: 3'b000};
        vecs[3] = '{cnt: 5'd16, bs: 32'd1,  exp_cyc: 1'b0, exp_cti: 3'b000};
        vecs[4] = '{cnt: 5'd15, bs: 32'd1,  exp_cyc: 1'b1, exp_cti: 3'b111};
        vecs[5] = '{cnt: 5'd0,  bs: 32'd16, exp_cyc: 1'b1, exp_cti: 3'b010};
        vecs[6] = '{cnt: 5'd1,  bs: 32'd16, exp_cyc: 1'b0, exp_cti: 3'b000};
        vecs[7] = '{cnt: 5'd8,  bs: 32'd8,  exp_cyc: 1'b1, exp_cti: 3'b010};

        // Reset values, with a stray ack present
        ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_tx", tx_cnt, 0);
        check("rst_cyc", 32'(cyc), 0);
        check("rst_stb", 32'(stb), 0);
        check("rst_cti", 32'(cti), 0);
        check("rst_fifo_wr", 32'(fifo_wr), 0);
        check("tie_we", 32'(we), 0);
        check("tie_sel", 32'(sel), 32'hF);
        check("tie_bte", 32'(bte), 0);
        check("tie_dat", dat_o, 0);
        ack = 1'b0;
        rst_n = 1'b1;

        // Launch condition table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            fifo_cnt = vecs[i].cnt;
            burst_size = vecs[i].bs;
            buf_size = vecs[i].bs * 8;
            start_adr = 32'h1000 + 32'(i * 256);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            check("vec_busy", 32'(busy), 1);
            check("vec_cyc_n", 32'(cyc), 0);
            @(negedge clk);
            check("vec_cyc", 32'(cyc), 32'(vecs[i].exp_cyc));
            check("vec_cti", 32'(cti), 32'(vecs[i].exp_cti));
            if (vecs[i].exp_cyc) check("vec_adr", adr, 32'h1000 + 32'(i * 256));
        end

        // Backpressure release
        do_reset();
        fifo_cnt = 5'd13; start_adr = 32'h1000; buf_size = 64; burst_size = 4;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_cyc", 32'(cyc), 0);
            check("bp_hold_busy", 32'(busy), 1);
        end
        fifo_cnt = 5'd12;
        @(negedge clk);
        check("bp_release_cyc", 32'(cyc), 1);
        check("bp_release_adr", adr, 32'h1000);
        do_reset();
        fifo_cnt = '0;

        // Basic, single-beat and wait-state transfers
        run_xfer(32'h1000, 32'd64, 32'd4, 0, 1'b0);
        run_xfer(32'h5000, 32'd8, 32'd1, 0, 1'b0);
        run_xfer(32'h4000, 32'd32, 32'd4, 2, 1'b0);

        // Bus error on beat 2, together with an ack
        do_reset();
        start_adr = 32'h2000; buf_size = 64; burst_size = 4;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("e_busy", 32'(busy), 1);
        @(negedge clk);
        check("e_cyc1", 32'(cyc), 1);
        check("e_adr1", adr, 32'h2000);
        ack = 1'b1; dat_i = 32'hCAFE0001;
        #1;
        check("e_push1", 32'(fifo_wr), 1);
        check("e_dat1", fifo_d, 32'hCAFE0001);
        @(negedge clk);
        check("e_adr2", adr, 32'h2004);
        werr = 1'b1;
        #1;
        check("e_nopush", 32'(fifo_wr), 0);
        @(negedge clk);
        ack = 1'b0; werr = 1'b0;
        check("e_cyc_drop", 32'(cyc), 0);
        check("e_err", 32'(err_o), 1);
        check("e_busy_clr", 32'(busy), 0);
        check("e_tx", tx_cnt, 1);
        @(negedge clk);
        check("e_idle", 32'(cyc), 0);
        check("e_sticky", 32'(err_o), 1);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check("e_err_clr", 32'(err_o), 0);
        check("e_rebusy", 32'(busy), 1);
        check("e_retx", tx_cnt, 0);
        @(negedge clk);
        check("e_recyc", 32'(cyc), 1);
        check("e_readr", adr, 32'h2000);

        // Reset during beat 3
        do_reset();
        start_adr = 32'h3000; buf_size = 64; burst_size = 4;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("r_adr1", adr, 32'h3000);
        ack = 1'b1;
        @(negedge clk);
        check("r_adr2", adr, 32'h3004);
        @(negedge clk);
        check("r_adr3", adr, 32'h3008);
        rst_n = 1'b0;
        @(negedge clk);
        check("r_cyc", 32'(cyc), 0);
        check("r_stb", 32'(stb), 0);
        check("r_cti", 32'(cti), 0);
        check("r_fifo_wr", 32'(fifo_wr), 0);
        check("r_busy", 32'(busy), 0);
        check("r_err", 32'(err_o), 0);
        check("r_tx", tx_cnt, 0);
        ack = 1'b0;
        rst_n = 1'b1;
        run_xfer(32'h3000, 32'd64, 32'd4, 0, 1'b0);

        // Randomized transfers with random ack and FIFO level
        for (int i = 0; i < 10; i++) begin
            logic [31:0] bs;
            logic [31:0] bsz;
            bs = 32'd1 << $urandom_range(0, 3);
            bsz = bs * 4 * 32'($urandom_range(1, 4));
            run_xfer($urandom & 32'hFFFF_FFFC, bsz, bs, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
